// File: rtl/cpu_pkg.sv
// Shared CPU constants: writeback result-select encodings, load opcodes and
// the register file geometry.
package cpu_pkg;

  localparam int NREG = 32;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC8 = 2'd2;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;

endpackage

// File: rtl/grf_wb_load_ext.sv
// Load extension: picks the addressed byte/half of a little-endian memory
// word and sign- or zero-extends it according to the load opcode.
module load_ext
  import cpu_pkg::*;
(
  input  logic [31:0] dr,
  input  logic [1:0]  off,
  input  logic [5:0]  op,
  output logic [31:0] ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    case (off)
      2'd0:    byte_s = $signed(dr[7:0]);
      2'd1:    byte_s = $signed(dr[15:8]);
      2'd2:    byte_s = $signed(dr[23:16]);
      default: byte_s = $signed(dr[31:24]);
    endcase
    half_s = off[1] ? $signed(dr[31:16]) : $signed(dr[15:0]);
  end

  always_comb begin
    case (op)
      OP_LB:   ext = 32'(byte_s);
      OP_LBU:  ext = {24'h0, byte_s};
      OP_LH:   ext = 32'(half_s);
      OP_LHU:  ext = {16'h0, half_s};
      default: ext = dr;
    endcase
  end

endmodule

// File: rtl/grf_wb.sv
// Writeback stage + 32x32 general register file with two combinational read
// ports. Define GRF_BYPASS_EN to forward the W-stage write onto the read ports.
module grf_wb
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_W,
  input  logic [31:0] PC8_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] DR_W,
  input  logic [4:0]  A3_W,
  input  logic [1:0]  Res_W,
  input  logic        j_zero_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_W,
  output logic        WE_W
);

  logic [31:0] rf [NREG];
  logic [31:0] mem_ext;
  logic        unused_bits;

  assign unused_bits = ^{IR_W[25:0], AO_W[31:2]};

  load_ext u_load_ext (
    .dr  (DR_W),
    .off (AO_W[1:0]),
    .op  (IR_W[31:26]),
    .ext (mem_ext)
  );

  always_comb begin
    case (Res_W)
      RES_ALU: WD_W = AO_W;
      RES_MEM: WD_W = mem_ext;
      RES_PC8: WD_W = PC8_W;
      default: WD_W = 32'h0;
    endcase
  end

  assign WE_W = (A3_W != 5'd0) && !j_zero_W && !reset;

  // Register 0 is never a write target, so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 32'h0;
    end else if (WE_W) begin
      rf[A3_W] <= WD_W;
    end
  end

  always_comb begin
    RD1 = (A1 == 5'd0) ? 32'h0 : rf[A1];
    RD2 = (A2 == 5'd0) ? 32'h0 : rf[A2];
`ifdef GRF_BYPASS_EN
    // WE_W already excludes address 0, so the bypass never touches reg 0.
    if (WE_W && (A1 == A3_W)) RD1 = WD_W;
    if (WE_W && (A2 == A3_W)) RD2 = WD_W;
`else
`endif
  end

endmodule

// File: tb/tb_grf_wb.sv
// Self-checking bench for grf_wb: directed vectors, multi-cycle sequences and
// randomized traffic against a behavioural register-file model.
module tb_grf_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_W, PC8_W, AO_W, DR_W;
  logic [4:0]  A3_W, A1, A2;
  logic [1:0]  Res_W;
  logic        j_zero_W;
  logic [31:0] RD1, RD2, WD_W;
  logic        WE_W;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  grf_wb dut (
    .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W),
    .DR_W(DR_W), .A3_W(A3_W), .Res_W(Res_W), .j_zero_W(j_zero_W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WD_W(WD_W), .WE_W(WE_W)
  );

  always #5 clk = ~clk;

  logic [31:0] model_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Step one clock; inputs change 1ns after the edge, checks happen later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_wd(input logic [1:0] res, input logic [5:0] op,
                                           input logic [31:0] ao, input logic [31:0] dr,
                                           input logic [31:0] pc8);
    logic [31:0] bv, hv, e;
    bv = (dr >> (8 * ao[1:0])) & 32'hFF;
    hv = (dr >> (16 * ao[1])) & 32'hFFFF;
    case (op)
      6'h20:   e = (bv >= 32'h80) ? (bv | 32'hFFFF_FF00) : bv;
      6'h24:   e = bv;
      6'h21:   e = (hv >= 32'h8000) ? (hv | 32'hFFFF_0000) : hv;
      6'h25:   e = hv;
      default: e = dr;
    endcase
    if (res == 2'd0)      return ao;
    else if (res == 2'd1) return e;
    else if (res == 2'd2) return pc8;
    else                  return 32'h0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    logic we;
    we = (A3_W != 0) && !j_zero_W && !reset;
    if (a == 0) return 32'h0;
    if (BYP && we && a == A3_W)
      return model_wd(Res_W, IR_W[31:26], AO_W, DR_W, PC8_W);
    return model_rf[a];
  endfunction

  typedef struct {
    logic [1:0]  res;
    logic [5:0]  op;
    logic [31:0] ao;
    logic [31:0] dr;
    logic [31:0] pc8;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{2'd1, 6'h20, 32'h0000_0002, 32'h80FF_7F01, 32'h0, 32'hFFFF_FFFF};
    vecs[1]  = '{2'd1, 6'h24, 32'h0000_0003, 32'h80FF_7F01, 32'h0, 32'h0000_0080};
    vecs[2]  = '{2'd1, 6'h21, 32'h0000_0002, 32'h80FF_7F01, 32'h0, 32'hFFFF_80FF};
    vecs[3]  = '{2'd1, 6'h25, 32'h0000_0000, 32'h80FF_7F01, 32'h0, 32'h0000_7F01};
    vecs[4]  = '{2'd1, 6'h23, 32'h0000_0001, 32'h80FF_7F01, 32'h0, 32'h80FF_7F01};
    vecs[5]  = '{2'd1, 6'h20, 32'h0000_0001, 32'h80FF_7F01, 32'h0, 32'h0000_007F};
    vecs[6]  = '{2'd1, 6'h21, 32'h0000_0000, 32'h80FF_7F01, 32'h0, 32'h0000_7F01};
    vecs[7]  = '{2'd1, 6'h24, 32'h0000_0000, 32'h80FF_7F01, 32'h0, 32'h0000_0001};
    vecs[8]  = '{2'd1, 6'h0F, 32'h0000_0003, 32'h80FF_7F01, 32'h0, 32'h80FF_7F01};
    vecs[9]  = '{2'd0, 6'h20, 32'h1234_5678, 32'h80FF_7F01, 32'h0000_3008, 32'h1234_5678};
    vecs[10] = '{2'd2, 6'h20, 32'h1234_5678, 32'h80FF_7F01, 32'h0000_3008, 32'h0000_3008};
    vecs[11] = '{2'd3, 6'h23, 32'h1234_5678, 32'h80FF_7F01, 32'h0000_3008, 32'h0000_0000};

    reset = 1'b1; IR_W = 32'h0; PC8_W = 32'h0; AO_W = 32'hAAAA_5555; DR_W = 32'h0;
    A3_W = 5'd9; Res_W = 2'd0; j_zero_W = 1'b0; A1 = 5'd0; A2 = 5'd0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;

    // Reset phase
    #1;
    chk("we_in_reset", {31'h0, WE_W}, 32'h0);
    tick();
    tick();
    reset = 1'b0; A3_W = 5'd0;
    #1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd1_%0d", i), RD1, 32'h0);
      chk($sformatf("rst_rd2_%0d", 31 - i), RD2, 32'h0);
    end

    // Directed writeback-select vectors (no write)
    foreach (vecs[k]) begin
      Res_W = vecs[k].res; IR_W = {vecs[k].op, 26'h0}; AO_W = vecs[k].ao;
      DR_W = vecs[k].dr; PC8_W = vecs[k].pc8;
      #1;
      chk($sformatf("wd_vec_%0d", k), WD_W, vecs[k].exp_wd);
    end

    // ALU write to reg 5, then attempted write to reg 0
    tick();
    Res_W = 2'd0; AO_W = 32'h1234_5678; A3_W = 5'd5; j_zero_W = 1'b0;
    #1;
    chk("we_reg5", {31'h0, WE_W}, 32'h1);
    tick();
    A3_W = 5'd0; A1 = 5'd5; A2 = 5'd0;
    #1;
    chk("reg5_rd1", RD1, 32'h1234_5678);
    chk("we_a3_zero", {31'h0, WE_W}, 32'h0);
    tick();
    chk("reg0_rd2", RD2, 32'h0);

    // Conditional link on reg 31
    Res_W = 2'd2; PC8_W = 32'h0000_3008; A3_W = 5'd31; j_zero_W = 1'b1; A1 = 5'd31;
    #1;
    chk("we_jzero", {31'h0, WE_W}, 32'h0);
    chk("reg31_jzero_same", RD1, 32'h0);
    tick();
    chk("reg31_unchanged", RD1, 32'h0);
    j_zero_W = 1'b0;
    tick();
    A3_W = 5'd0;
    #1;
    chk("reg31_link", RD1, 32'h0000_3008);

    // Same-cycle read/write of reg 8
    Res_W = 2'd0; AO_W = 32'hDEAD_BEEF; A3_W = 5'd8; A1 = 5'd8; A2 = 5'd8;
    #1;
    chk("byp_rd1", RD1, BYP ? 32'hDEAD_BEEF : 32'h0);
    chk("byp_rd2", RD2, BYP ? 32'hDEAD_BEEF : 32'h0);
    tick();
    A3_W = 5'd0;
    #1;
    chk("reg8_next_rd1", RD1, 32'hDEAD_BEEF);
    chk("reg8_next_rd2", RD2, 32'hDEAD_BEEF);

    // Reset while a write to reg 9 is pending
    reset = 1'b1; A3_W = 5'd9; AO_W = 32'hCAFE_F00D; A1 = 5'd9; A2 = 5'd5;
    #1;
    chk("we_reset_mid", {31'h0, WE_W}, 32'h0);
    tick();
    reset = 1'b0; A3_W = 5'd0;
    #1;
    chk("reg9_after_reset", RD1, 32'h0);
    chk("reg5_after_reset", RD2, 32'h0);

    // Randomized traffic against the model (model_rf is all-zero after reset)
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    for (int c = 0; c < 400; c++) begin
      logic [5:0] ops [6];
      logic [31:0] exp_wd;
      logic        exp_we;
      ops = '{6'h23, 6'h20, 6'h24, 6'h21, 6'h25, 6'($urandom)};
      reset    = ($urandom_range(0, 49) == 0);
      Res_W    = 2'($urandom);
      IR_W     = {ops[$urandom_range(0, 5)], 26'($urandom)};
      AO_W     = $urandom; DR_W = $urandom; PC8_W = $urandom;
      A3_W     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      j_zero_W = ($urandom_range(0, 3) == 0);
      A1       = ($urandom_range(0, 2) == 0) ? A3_W : 5'($urandom_range(0, 7));
      A2       = ($urandom_range(0, 2) == 0) ? A3_W : 5'($urandom_range(0, 7));
      #1;
      exp_wd = model_wd(Res_W, IR_W[31:26], AO_W, DR_W, PC8_W);
      exp_we = (A3_W != 0) && !j_zero_W && !reset;
      chk("rnd_wd", WD_W, exp_wd);
      chk("rnd_we", {31'h0, WE_W}, {31'h0, exp_we});
      chk("rnd_rd1", RD1, model_rd(A1));
      chk("rnd_rd2", RD2, model_rd(A2));
      if (reset) for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
      else if (exp_we) model_rf[A3_W] = exp_wd;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
